// File: rtl/adc_result_fifo.sv
// Captures delta-sigma ADC results, averages 1/2/4/8 consecutive samples
// into one word and buffers the words in a show-ahead FIFO.
module adc_result_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 16
) (
  input  logic                  clk_vcm,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      result_in,
  input  logic                  conversion_finished_in,
  input  logic [1:0]            avg_log2_in,
  input  logic                  clear_in,
  input  logic                  rd_en_in,
  output logic [WIDTH-1:0]      rd_data_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic [DEPTH_LOG2:0]   count_out,
  output logic                  overflow_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACC_W = WIDTH + 3;

  logic                  done_q;
  logic [ACC_W-1:0]      acc;
  logic [2:0]            scnt;
  logic [1:0]            avg_q;
  logic [DEPTH_LOG2:0]   wptr, rptr;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  sample_evt;
  logic [1:0]            eff_avg;
  logic [2:0]            last_idx;
  logic [ACC_W-1:0]      sum;
  logic                  block_done;
  logic [WIDTH-1:0]      word;
  logic                  push, pop, wr_en, drop;

  // done_q resets high so a level already high at reset release is not an event.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_vcm or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b1;
    else        done_q <= conversion_finished_in;
  end

  assign sample_evt = conversion_finished_in & ~done_q;

  // The averaging factor is sampled at the start of a block and held for its duration.
  assign eff_avg    = (scnt == 3'd0) ? avg_log2_in : avg_q;
  assign last_idx   = 3'((4'd1 << eff_avg) - 4'd1);
  assign sum        = acc + ACC_W'(result_in);
  assign block_done = sample_evt && (scnt == last_idx);
  assign word       = WIDTH'(sum >> eff_avg);

  always_ff @(posedge clk_vcm or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      scnt  <= '0;
      avg_q <= '0;
    end else if (clear_in) begin
      acc  <= '0;
      scnt <= '0;
    end else if (sample_evt) begin
      if (scnt == 3'd0) avg_q <= avg_log2_in;
      if (block_done) begin
        acc  <= '0;
        scnt <= '0;
      end else begin
        acc  <= sum;
        scnt <= scnt + 3'd1;
      end
    end
  end

  // Pointer-derived status; the extra MSB distinguishes full from empty.
  assign empty_out = (wptr == rptr);
  assign full_out  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                     (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign count_out = wptr - rptr;

  assign push  = block_done & ~clear_in;
  assign pop   = rd_en_in & ~empty_out & ~clear_in;
  assign wr_en = push & (~full_out | pop);
  assign drop  = push & full_out & ~pop;

  always_ff @(posedge clk_vcm or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      overflow_out <= 1'b0;
    end else if (clear_in) begin
      wptr         <= '0;
      rptr         <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (drop)  overflow_out <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty_out gates the read data,
  // so stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk_vcm) begin
    if (wr_en) mem[wptr[DEPTH_LOG2-1:0]] <= word;
  end

  assign rd_data_out = empty_out ? '0 : mem[rptr[DEPTH_LOG2-1:0]];

endmodule

// File: tb/tb_adc_result_fifo.sv
// Directed bench for adc_result_fifo: table-driven fill/overflow vectors plus
// hand-written sequences for reset, averaging, level-hold and clear behaviour.
module tb_adc_result_fifo;

  logic        clk_vcm = 1'b0;
  logic        rst_n;
  logic [15:0] result_in;
  logic        conversion_finished_in;
  logic [1:0]  avg_log2_in;
  logic        clear_in;
  logic        rd_en_in;
  logic [15:0] rd_data_out;
  logic        empty_out;
  logic        full_out;
  logic [3:0]  count_out;
  logic        overflow_out;

  int checks = 0;
  int errors = 0;

  adc_result_fifo #(.DEPTH_LOG2(3), .WIDTH(16)) dut (
    .clk_vcm                (clk_vcm),
    .rst_n                  (rst_n),
    .result_in              (result_in),
    .conversion_finished_in (conversion_finished_in),
    .avg_log2_in            (avg_log2_in),
    .clear_in               (clear_in),
    .rd_en_in               (rd_en_in),
    .rd_data_out            (rd_data_out),
    .empty_out              (empty_out),
    .full_out               (full_out),
    .count_out              (count_out),
    .overflow_out           (overflow_out)
  );

  always #5 clk_vcm = ~clk_vcm;

  typedef struct {
    logic [15:0] result;
    logic        rd;
    logic [3:0]  exp_count;
    logic [15:0] exp_data;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_vcm);
    #1;
  endtask

  task automatic pulse(input logic [15:0] r, input logic rd);
    result_in = r;
    conversion_finished_in = 1'b1;
    rd_en_in = rd;
    tick();
    conversion_finished_in = 1'b0;
    rd_en_in = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_en_in = 1'b1;
    tick();
    rd_en_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{16'h0100 + 16'(i), 1'b0, 4'(i + 1), 16'h0100, (i == 7), 1'b0};
    vecs[8] = '{16'h0108, 1'b0, 4'd8, 16'h0100, 1'b1, 1'b1};
    vecs[9] = '{16'h0109, 1'b1, 4'd8, 16'h0101, 1'b1, 1'b1};

    rst_n = 1'b0;
    result_in = '0;
    conversion_finished_in = 1'b1;
    avg_log2_in = 2'd0;
    clear_in = 1'b0;
    rd_en_in = 1'b0;

    // Reset with the done level held high across release.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("no_push_level_at_reset", 32'(count_out), 0);
    conversion_finished_in = 1'b0;
    repeat (10) tick();
    check("reset_empty", 32'(empty_out), 1);
    check("reset_full", 32'(full_out), 0);
    check("reset_count", 32'(count_out), 0);
    check("reset_ovf", 32'(overflow_out), 0);
    check("reset_data", 32'(rd_data_out), 0);

    // Pop while empty is ignored.
    pop_one();
    check("pop_empty_count", 32'(count_out), 0);

    // No averaging: one-cycle latency, ordered reads, then empty.
    result_in = 16'h1234;
    conversion_finished_in = 1'b1;
    tick();
    check("latency_count", 32'(count_out), 1);
    check("latency_data", 32'(rd_data_out), 32'h1234);
    conversion_finished_in = 1'b0;
    tick();
    pulse(16'hFFFF, 1'b0);
    pulse(16'h0001, 1'b0);
    check("avg1_count3", 32'(count_out), 3);
    check("avg1_head0", 32'(rd_data_out), 32'h1234);
    pop_one();
    check("avg1_head1", 32'(rd_data_out), 32'hFFFF);
    pop_one();
    check("avg1_head2", 32'(rd_data_out), 32'h0001);
    pop_one();
    check("avg1_empty", 32'(empty_out), 1);
    check("avg1_empty_data", 32'(rd_data_out), 0);

    // Average of 4: 10..13 -> 46/4 = 11.
    avg_log2_in = 2'd2;
    pulse(16'd10, 1'b0);
    pulse(16'd11, 1'b0);
    pulse(16'd12, 1'b0);
    check("avg4_partial", 32'(count_out), 0);
    pulse(16'd13, 1'b0);
    check("avg4_count", 32'(count_out), 1);
    check("avg4_word", 32'(rd_data_out), 11);
    pop_one();

    // Average of 4 full-scale samples stays full-scale.
    for (int i = 0; i < 4; i++) pulse(16'hFFFF, 1'b0);
    check("avg4_max_count", 32'(count_out), 1);
    check("avg4_max_word", 32'(rd_data_out), 32'hFFFF);
    pop_one();

    // Factor change mid-block applies only to the next block: (4+8+12+16)/4 = 10.
    pulse(16'd4, 1'b0);
    pulse(16'd8, 1'b0);
    avg_log2_in = 2'd0;
    pulse(16'd12, 1'b0);
    check("midchg_partial", 32'(count_out), 0);
    pulse(16'd16, 1'b0);
    check("midchg_count", 32'(count_out), 1);
    check("midchg_word", 32'(rd_data_out), 10);
    pop_one();

    // Fill, overflow, and simultaneous push/pop while full.
    for (int i = 0; i < 10; i++) begin
      pulse(vecs[i].result, vecs[i].rd);
      check($sformatf("fill%0d_count", i), 32'(count_out), 32'(vecs[i].exp_count));
      check($sformatf("fill%0d_data", i), 32'(rd_data_out), 32'(vecs[i].exp_data));
      check($sformatf("fill%0d_full", i), 32'(full_out), 32'(vecs[i].exp_full));
      check($sformatf("fill%0d_ovf", i), 32'(overflow_out), 32'(vecs[i].exp_ovf));
    end
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d", k), 32'(rd_data_out), (k < 7) ? 32'h0101 + 32'(k) : 32'h0109);
      pop_one();
    end
    check("drain_empty", 32'(empty_out), 1);
    check("ovf_sticky", 32'(overflow_out), 1);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("clear_ovf", 32'(overflow_out), 0);

    // A level held high for 20 cycles is a single event.
    result_in = 16'h00AA;
    conversion_finished_in = 1'b1;
    repeat (20) tick();
    conversion_finished_in = 1'b0;
    tick();
    check("hold_count", 32'(count_out), 1);
    check("hold_data", 32'(rd_data_out), 32'h00AA);
    pop_one();

    // Clear discards a partial block.
    avg_log2_in = 2'd2;
    pulse(16'd100, 1'b0);
    pulse(16'd100, 1'b0);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    for (int i = 0; i < 4; i++) pulse(16'd8, 1'b0);
    check("clear_block_count", 32'(count_out), 1);
    check("clear_block_word", 32'(rd_data_out), 8);
    check("clear_block_ovf", 32'(overflow_out), 0);

    // Clear wins over an event on the same edge.
    avg_log2_in = 2'd0;
    result_in = 16'h5555;
    conversion_finished_in = 1'b1;
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    conversion_finished_in = 1'b0;
    tick();
    check("clear_prio_count", 32'(count_out), 0);

    // Asynchronous reset mid-cycle with data stored.
    pulse(16'h7777, 1'b0);
    check("pre_arst_count", 32'(count_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty_out), 1);
    check("arst_data", 32'(rd_data_out), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_result_fifo.md
# adc_result_fifo

Downstream companion of the delta-sigma ADC top. It captures every finished conversion result and optionally averages 1/2/4/8 consecutive results into one word. Averaged words are buffered in a small FIFO, which the SoC-side logic drains with a show-ahead read handshake. It runs on the ADC clock domain and flags lost words.

## Interface

Parameters:
- DEPTH_LOG2, 3, FIFO depth is 2^DEPTH_LOG2 words (default 8).
- WIDTH, 16, result and word width; matches the ADC result bus.

Ports:
- clk_vcm  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- result_in  input  WIDTH  ADC conversion result, unsigned.
- conversion_finished_in  input  1  ADC done level; a result is valid while high.
- avg_log2_in  input  2  averaging factor; 0..3 means 1, 2, 4 or 8 samples per word.
- clear_in  input  1  synchronous flush.
- rd_en_in  input  1  pop request.
- rd_data_out  output  WIDTH  head-of-FIFO word (show-ahead).
- empty_out  output  1  FIFO empty.
- full_out  output  1  FIFO full.
- count_out  output  DEPTH_LOG2+1  words stored.
- overflow_out  output  1  sticky word-lost flag.

## Operation

- Event detection:
  - Register done_q holds conversion_finished_in from the previous cycle; reset value 1.
  - A sample event is conversion_finished_in=1 with done_q=0.
  - A level held high produces exactly one event.
  - A level already high when reset releases produces no event.
- Averaging:
  - 19-bit unsigned accumulator acc and 3-bit sample counter scnt.
  - avg_log2_in is latched into avg_q on the event where scnt==0. Changes in mid-block take effect at the next block.
  - On each event the sum is acc+result_in.
  - If scnt == 2^avg_q−1:
    - the word (acc+result_in)>>avg_q, truncated to WIDTH bits, is pushed;
    - acc and scnt clear.
  - Otherwise acc takes the sum and scnt increments.
  - The result never exceeds 16'hFFFF, because the truncation divides by the sample count.
- FIFO:
  - Circular buffer with DEPTH_LOG2+1-bit read and write pointers, so 2^DEPTH_LOG2 words are usable.
  - Pop occurs when rd_en_in=1 and not empty.
  - rd_en_in while empty is ignored.
  - Push while not full writes mem[wptr].
  - Push while full and no pop in the same cycle drops the word and sets overflow_out.
  - Push and pop in the same cycle while full both succeed; count is unchanged and overflow_out is not set.
  - Push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo 2^DEPTH_LOG2 on the address bits.
- Outputs:
  - rd_data_out = mem[rptr] when not empty, else all zeros.
  - empty_out, full_out and count_out are derived from the pointers.
- clear_in:
  - Zeroes the pointers, acc, scnt and overflow_out.
  - Has priority over any push or pop in the same cycle.
  - Does not change done_q.
- Reset values:
  - rd_data_out=0, empty_out=1, full_out=0, count_out=0, overflow_out=0.
  - acc=0, scnt=0, avg_q=0, done_q=1.

## Timing

- Edge N is the first rising edge that samples conversion_finished_in=1.
- If edge N completes a block:
  - the word is written at edge N;
  - empty_out, count_out and rd_data_out reflect it after edge N;
  - latency is 1 cycle from conversion_finished_in rising to data visible.
- Pop at edge M: after edge M, rd_data_out shows the next word, or 0 if the FIFO is now empty.
- overflow_out rises after the edge where a word is dropped. It stays high until clear_in or reset.
- clear_in sampled high at edge K: all state is cleared after edge K. An event at edge K is discarded.
- rst_n low asynchronously forces all reset values, including in mid-block or in mid-read.
- Throughput: one event per 2 cycles maximum, since conversion_finished_in must return low between events.

## Test plan

- Reset, then idle for 10 cycles:
  - required: empty_out=1, full_out=0, count_out=0, overflow_out=0, rd_data_out=0.
  - Hold conversion_finished_in=1 across reset release: required no push.
- avg_log2_in=0, three done pulses with 16'h1234, 16'hFFFF, 16'h0001:
  - required: count_out=3 one cycle after the third pulse;
  - reads return the three words in that order, then empty_out=1.
- avg_log2_in=2:
  - results 10, 11, 12, 13: required one word, 11.
  - four results of 16'hFFFF: required one word, 16'hFFFF.
  - change avg_log2_in to 0 after the 2nd sample: required the block still averages 4 samples.
- avg_log2_in=0, 9 pulses with no reads:
  - required after the 8th pulse: full_out=1, count_out=8.
  - required after the 9th pulse: overflow_out=1 and the head word is still the 1st result.
  - then a pulse with rd_en_in=1 in the same cycle: required count_out=8 and rd_data_out=the 2nd result.
- conversion_finished_in held high for 20 cycles with result 16'h00AA: required exactly one push.
- avg_log2_in=2, 2 samples of 100, then clear_in, then 4 samples of 8:
  - required: a single word of 8 and overflow_out=0.
